// File: rtl/arb_response_router.sv
// In-order return path: records the arbiter's winner per issue and steers each response back to it as a one-hot valid.
// Response reaches out_vld one cycle after resp_vld; issue_rdy drops when Depth tags are outstanding.
module arb_response_router #(
  parameter int NumRequests = 8,
  parameter int Depth       = 8,
  parameter int DataWidth   = 64,
  localparam int IdW        = $clog2(NumRequests) + 1,
  localparam int PtrW       = $clog2(Depth),
  localparam int CntW       = $clog2(Depth) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic                   issue_vld,
  input  logic [IdW-1:0]         issue_id,
  output logic                   issue_rdy,
  input  logic                   resp_vld,
  input  logic [DataWidth-1:0]   resp_data,
  input  logic                   resp_err,
  output logic [NumRequests-1:0] out_vld,
  output logic [DataWidth-1:0]   out_data,
  output logic                   out_err,
  output logic [IdW-1:0]         out_id,
  output logic [CntW-1:0]        count,
  output logic [1:0]             err_sticky
);

  logic [IdW-1:0]         tags [Depth];
  logic [PtrW-1:0]        wptr;
  logic [PtrW-1:0]        rptr;
  logic                   id_ok;
  logic                   push;
  logic                   pop;
  logic                   orphan;
  logic                   bad_id;
  logic [IdW-1:0]         head;
  logic [NumRequests-1:0] head_onehot;

  assign issue_rdy   = (count != CntW'(Depth));
  assign id_ok       = (issue_id < IdW'(NumRequests));
  assign push        = ce & issue_vld & issue_rdy & id_ok;
  assign bad_id      = ce & issue_vld & ~id_ok;
  assign pop         = ce & resp_vld & (count != '0);
  assign orphan      = ce & resp_vld & (count == '0);
  assign head        = tags[rptr];
  // Stored tags are always < NumRequests, so the shift yields exactly one bit.
  assign head_onehot = NumRequests'(1) << head;

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      tags[wptr] <= issue_id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      out_vld    <= '0;
      out_data   <= '0;
      out_err    <= 1'b0;
      out_id     <= '0;
      err_sticky <= '0;
    end else if (ce) begin
      if (push) begin
        wptr <= wptr + PtrW'(1);
      end
      if (pop) begin
        rptr     <= rptr + PtrW'(1);
        out_data <= resp_data;
        out_err  <= resp_err;
        out_id   <= head;
      end
      count      <= count + CntW'(push) - CntW'(pop);
      out_vld    <= pop ? head_onehot : '0;
      err_sticky <= err_sticky | {bad_id, orphan};
    end
  end

endmodule

// File: tb/tb_arb_response_router.sv
// Directed table-driven bench for arb_response_router: one row per clock, expected post-edge state hand-computed.
module tb_arb_response_router;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic        issue_vld;
  logic [3:0]  issue_id;
  logic        issue_rdy;
  logic        resp_vld;
  logic [63:0] resp_data;
  logic        resp_err;
  logic [7:0]  out_vld;
  logic [63:0] out_data;
  logic        out_err;
  logic [3:0]  out_id;
  logic [3:0]  count;
  logic [1:0]  err_sticky;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    string       name;
    logic        rst;
    logic        ce;
    logic        iv;
    logic [3:0]  id;
    logic        rv;
    logic [63:0] rd;
    logic        re;
    logic [7:0]  e_vld;
    logic [63:0] e_data;
    logic        e_err;
    logic [3:0]  e_id;
    logic [3:0]  e_cnt;
    logic        e_rdy;
    logic [1:0]  e_st;
  } vec_t;

  vec_t vecs[$];

  arb_response_router #(.NumRequests(8), .Depth(8), .DataWidth(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .issue_vld  (issue_vld),
    .issue_id   (issue_id),
    .issue_rdy  (issue_rdy),
    .resp_vld   (resp_vld),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .out_vld    (out_vld),
    .out_data   (out_data),
    .out_err    (out_err),
    .out_id     (out_id),
    .count      (count),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic add(input string nm, input logic r, input logic c, input logic iv, input logic [3:0] id,
                     input logic rv, input logic [63:0] rd, input logic re,
                     input logic [7:0] ev, input logic [63:0] ed, input logic ee, input logic [3:0] eid,
                     input logic [3:0] ec, input logic er, input logic [1:0] es);
    vec_t v;
    v.name = nm; v.rst = r; v.ce = c; v.iv = iv; v.id = id; v.rv = rv; v.rd = rd; v.re = re;
    v.e_vld = ev; v.e_data = ed; v.e_err = ee; v.e_id = eid; v.e_cnt = ec; v.e_rdy = er; v.e_st = es;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic c, input logic iv, input logic [3:0] id,
                       input logic rv, input logic [63:0] rd, input logic re);
    @(negedge clk);
    rst = r; ce = c; issue_vld = iv; issue_id = id; resp_vld = rv; resp_data = rd; resp_err = re;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; issue_vld = 1'b0; issue_id = '0;
    resp_vld = 1'b0; resp_data = '0; resp_err = 1'b0;

    // Directed vectors: name, rst, ce, issue_vld, issue_id, resp_vld, resp_data, resp_err,
    // then expected out_vld, out_data, out_err, out_id, count, issue_rdy, err_sticky.
    add("iss3",  0,1, 1,4'd3, 0,64'h0,0,   8'h00,64'h0,0,4'd0, 4'd1,1,2'b00);
    add("iss0",  0,1, 1,4'd0, 0,64'h0,0,   8'h00,64'h0,0,4'd0, 4'd2,1,2'b00);
    add("iss7",  0,1, 1,4'd7, 0,64'h0,0,   8'h00,64'h0,0,4'd0, 4'd3,1,2'b00);
    add("rspA",  0,1, 0,4'd0, 1,64'hA,0,   8'h08,64'hA,0,4'd3, 4'd2,1,2'b00);
    add("rspB",  0,1, 0,4'd0, 1,64'hB,1,   8'h01,64'hB,1,4'd0, 4'd1,1,2'b00);
    add("rspC",  0,1, 0,4'd0, 1,64'hC,0,   8'h80,64'hC,0,4'd7, 4'd0,1,2'b00);
    add("idle",  0,1, 0,4'd0, 0,64'h0,0,   8'h00,64'hC,0,4'd7, 4'd0,1,2'b00);
    for (int i = 1; i <= 8; i++)
      add("fill5", 0,1, 1,4'd5, 0,64'h0,0, 8'h00,64'hC,0,4'd7, 4'(i),(i != 8),2'b00);
    add("drop9", 0,1, 1,4'd5, 0,64'h0,0,   8'h00,64'hC,0,4'd7, 4'd8,0,2'b00);
    add("popf",  0,1, 0,4'd0, 1,64'h55,0,  8'h20,64'h55,0,4'd5, 4'd7,1,2'b00);
    add("pshpop",0,1, 1,4'd5, 1,64'h66,0,  8'h20,64'h66,0,4'd5, 4'd7,1,2'b00);
    for (int i = 0; i < 7; i++)
      add("drain", 0,1, 0,4'd0, 1,64'(8'h70 + i),0, 8'h20,64'(8'h70 + i),0,4'd5, 4'(6 - i),1,2'b00);
    add("orph",  0,1, 0,4'd0, 1,64'h99,1,  8'h00,64'h76,0,4'd5, 4'd0,1,2'b01);
    add("orpiss",0,1, 1,4'd2, 1,64'h98,1,  8'h00,64'h76,0,4'd5, 4'd1,1,2'b01);
    add("rsp2",  0,1, 0,4'd0, 1,64'h22,0,  8'h04,64'h22,0,4'd2, 4'd0,1,2'b01);
    add("badF",  0,1, 1,4'hF, 0,64'h0,0,   8'h00,64'h22,0,4'd2, 4'd0,1,2'b11);
    add("bad8",  0,1, 1,4'h8, 0,64'h0,0,   8'h00,64'h22,0,4'd2, 4'd0,1,2'b11);
    add("iss1",  0,1, 1,4'd1, 0,64'h0,0,   8'h00,64'h22,0,4'd2, 4'd1,1,2'b11);
    add("iss6",  0,1, 1,4'd6, 0,64'h0,0,   8'h00,64'h22,0,4'd2, 4'd2,1,2'b11);
    for (int i = 0; i < 3; i++)
      add("ceoff", 0,0, 0,4'd0, 1,64'hEE,1, 8'h00,64'h22,0,4'd2, 4'd2,1,2'b11);
    add("ceon1", 0,1, 0,4'd0, 1,64'hE1,0,  8'h02,64'hE1,0,4'd1, 4'd1,1,2'b11);
    add("ceon2", 0,1, 0,4'd0, 1,64'hE2,1,  8'h40,64'hE2,1,4'd6, 4'd0,1,2'b11);
    add("iss4",  0,1, 1,4'd4, 0,64'h0,0,   8'h00,64'hE2,1,4'd6, 4'd1,1,2'b11);
    add("rsp4",  0,1, 0,4'd0, 1,64'h44,0,  8'h10,64'h44,0,4'd4, 4'd0,1,2'b11);
    for (int i = 0; i < 2; i++)
      add("pulhld",0,0, 1,4'd3, 0,64'h0,0, 8'h10,64'h44,0,4'd4, 4'd0,1,2'b11);
    add("pulend",0,1, 0,4'd0, 0,64'h0,0,   8'h00,64'h44,0,4'd4, 4'd0,1,2'b11);
    add("o1",    0,1, 1,4'd1, 0,64'h0,0,   8'h00,64'h44,0,4'd4, 4'd1,1,2'b11);
    add("o2",    0,1, 1,4'd2, 0,64'h0,0,   8'h00,64'h44,0,4'd4, 4'd2,1,2'b11);
    add("o3",    0,1, 1,4'd3, 0,64'h0,0,   8'h00,64'h44,0,4'd4, 4'd3,1,2'b11);
    add("rstce0",1,0, 0,4'd0, 1,64'h33,1,  8'h00,64'h0,0,4'd0, 4'd0,1,2'b00);
    add("postor",0,1, 0,4'd0, 1,64'h77,1,  8'h00,64'h0,0,4'd0, 4'd0,1,2'b01);

    // Reset, then ten idle cycles.
    drive(1, 1, 0, 4'd0, 0, 64'h0, 0);
    drive(1, 1, 0, 4'd0, 0, 64'h0, 0);
    check("rst_vld", 64'(out_vld), 64'h0);
    check("rst_data", out_data, 64'h0);
    check("rst_err", 64'(out_err), 64'h0);
    check("rst_id", 64'(out_id), 64'h0);
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 0, 4'd0, 0, 64'h0, 0);
      check("idle_cnt", 64'(count), 64'h0);
      check("idle_rdy", 64'(issue_rdy), 64'h1);
      check("idle_vld", 64'(out_vld), 64'h0);
      check("idle_st", 64'(err_sticky), 64'h0);
    end

    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].ce, vecs[k].iv, vecs[k].id, vecs[k].rv, vecs[k].rd, vecs[k].re);
      check({vecs[k].name, ".vld"},  64'(out_vld),    64'(vecs[k].e_vld));
      check({vecs[k].name, ".data"}, out_data,        vecs[k].e_data);
      check({vecs[k].name, ".err"},  64'(out_err),    64'(vecs[k].e_err));
      check({vecs[k].name, ".id"},   64'(out_id),     64'(vecs[k].e_id));
      check({vecs[k].name, ".cnt"},  64'(count),      64'(vecs[k].e_cnt));
      check({vecs[k].name, ".rdy"},  64'(issue_rdy),  64'(vecs[k].e_rdy));
      check({vecs[k].name, ".st"},   64'(err_sticky), 64'(vecs[k].e_st));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
